// File: rtl/axis_src_pkg.sv
// Shared definitions for the AXI4-Stream sample source: waveform modes, FSM states and
// default sample width.
package axis_src_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   localparam logic [1:0] MODE_IMPULSE = 2'd0;
   localparam logic [1:0] MODE_STEP    = 2'd1;
   localparam logic [1:0] MODE_RAMP    = 2'd2;
   localparam logic [1:0] MODE_ALT     = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_e;

endpackage

// File: rtl/axis_sample_value_gen.sv
// Waveform state (ramp accumulator, alternating sign, impulse first-beat flag).
// sample_o is the value for the index that becomes current after this cycle's clear/advance.
module axis_sample_value_gen
   import axis_src_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              advance_i,
   input  logic [1:0]        mode_i,
   input  logic [DATA_W-1:0] amplitude_i,
   output logic [DATA_W-1:0] sample_o
);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic              odd_q, odd_d;
   logic              first_q, first_d;

   always_comb begin
      acc_d   = acc_q;
      odd_d   = odd_q;
      first_d = first_q;
      if (clear_i) begin
         acc_d   = '0;
         odd_d   = 1'b0;
         first_d = 1'b1;
      end else if (advance_i) begin
         acc_d   = acc_q + amplitude_i;
         odd_d   = ~odd_q;
         first_d = 1'b0;
      end
   end

   // Decoded from next-state so the top can register it on the same edge.
   always_comb begin
      sample_o = '0;
      unique case (mode_i)
         MODE_IMPULSE: sample_o = first_d ? amplitude_i : '0;
         MODE_STEP:    sample_o = amplitude_i;
         MODE_RAMP:    sample_o = acc_d;
         MODE_ALT:     sample_o = odd_d ? ('0 - amplitude_i) : amplitude_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q   <= '0;
         odd_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         odd_q   <= odd_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/axis_sample_source.sv
// AXI4-Stream master emitting impulse/step/ramp/alternating bursts with programmable
// length and inter-beat gap; obeys tready backpressure.
module axis_sample_source
   import axis_src_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic [DATA_W-1:0] amplitude,
   input  logic [DIV_W-1:0]  rate_div,
   output logic              m_axis_data_tvalid,
   output logic [DATA_W-1:0] m_axis_data_tdata,
   input  logic              m_axis_data_tready,
   output logic              m_axis_data_tlast,
   output logic              busy,
   output logic              done
);

   state_e            state_q;
   logic [1:0]        mode_q;
   logic [CNT_W-1:0]  num_q;
   logic [DATA_W-1:0] amp_q;
   logic [DIV_W-1:0]  div_q;
   logic [CNT_W-1:0]  idx_q;
   logic [DIV_W-1:0]  gap_q;
   logic              tvalid_q, tlast_q, busy_q, done_q;
   logic [DATA_W-1:0] tdata_q;

   logic              start_acc, advance;
   logic [1:0]        gen_mode;
   logic [DATA_W-1:0] gen_amp, sample;
   logic [CNT_W-1:0]  idx_nxt, last_idx;

   assign start_acc = (state_q == IDLE) && start;
   assign advance   = (state_q == SEND) && m_axis_data_tready && !tlast_q;
   // Config is captured on the same edge the first sample is produced, so bypass it.
   assign gen_mode  = start_acc ? mode : mode_q;
   assign gen_amp   = start_acc ? amplitude : amp_q;
   assign idx_nxt   = idx_q + CNT_W'(1);
   assign last_idx  = num_q - CNT_W'(1);

   axis_sample_value_gen #(
      .DATA_W(DATA_W)
   ) u_value_gen (
      .clk_i      (aclk),
      .rst_ni     (aresetn),
      .clear_i    (start_acc),
      .advance_i  (advance),
      .mode_i     (gen_mode),
      .amplitude_i(gen_amp),
      .sample_o   (sample)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         mode_q   <= '0;
         num_q    <= '0;
         amp_q    <= '0;
         div_q    <= '0;
         idx_q    <= '0;
         gap_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  num_q  <= num_samples;
                  amp_q  <= amplitude;
                  div_q  <= rate_div;
                  idx_q  <= '0;
                  if (num_samples == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q  <= SEND;
                     tvalid_q <= 1'b1;
                     busy_q   <= 1'b1;
                     tdata_q  <= sample;
                     tlast_q  <= (num_samples == CNT_W'(1));
                  end
               end
            end
            SEND: begin
               if (m_axis_data_tready) begin
                  if (tlast_q) begin
                     state_q  <= IDLE;
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     idx_q   <= idx_nxt;
                     tdata_q <= sample;
                     if (div_q == '0) begin
                        tlast_q <= (idx_nxt == last_idx);
                     end else begin
                        state_q  <= GAP;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        gap_q    <= div_q;
                     end
                  end
               end
            end
            GAP: begin
               if (gap_q == DIV_W'(1)) begin
                  state_q  <= SEND;
                  tvalid_q <= 1'b1;
                  tlast_q  <= (idx_q == last_idx);
               end else begin
                  gap_q <= gap_q - DIV_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_axis_data_tvalid = tvalid_q;
   assign m_axis_data_tdata  = tdata_q;
   assign m_axis_data_tlast  = tlast_q;
   assign busy               = busy_q;
   assign done               = done_q;

endmodule

// File: tb/tb_axis_sample_source.sv
// Self-checking bench for axis_sample_source: directed table of bursts, random bursts,
// reset-mid-burst and maximum-length burst, all checked against a per-index sample model.
module tb_axis_sample_source;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = '0;
   logic [15:0] num_samples = '0;
   logic [15:0] amplitude = '0;
   logic [7:0]  rate_div = '0;
   logic        tready = 1'b0;
   logic        tvalid, tlast, busy, done;
   logic [15:0] tdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   axis_sample_source #(
      .DATA_W(16),
      .CNT_W (16),
      .DIV_W (8)
   ) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .start             (start),
      .mode              (mode),
      .num_samples       (num_samples),
      .amplitude         (amplitude),
      .rate_div          (rate_div),
      .m_axis_data_tvalid(tvalid),
      .m_axis_data_tdata (tdata),
      .m_axis_data_tready(tready),
      .m_axis_data_tlast (tlast),
      .busy              (busy),
      .done              (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sample k of a burst, straight from the waveform definitions.
   function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] a, input int k);
      logic [15:0] kk;
      kk = k[15:0];
      case (m)
         2'd0:    return (k == 0) ? a : 16'h0000;
         2'd1:    return a;
         2'd2:    return 16'(kk * a);
         default: return (k % 2 == 1) ? 16'(16'h0000 - a) : a;
      endcase
   endfunction

   task automatic run_burst(input logic [1:0] m, input int n, input logic [15:0] a,
                            input int dv, input int pct, input int stall,
                            output logic [15:0] first_v, output logic [15:0] final_v,
                            output int beats);
      int   k, since, budget;
      logic v, hs, after_hs, prev_v, prev_hs, fin;
      k = 0; since = 0; after_hs = 0; prev_v = 0; prev_hs = 0; fin = 0;
      first_v = '0; final_v = '0; beats = 0;
      budget = (n + 4) * (dv + 2) * 20;
      @(negedge aclk);
      start = 1'b1; mode = m; num_samples = 16'(n); amplitude = a; rate_div = 8'(dv);
      tready = 1'b0;
      for (int cyc = 0; cyc < budget && !fin; cyc++) begin
         @(negedge aclk);
         start = 1'b0;
         v = tvalid;
         if (cyc == 0) chk("first_latency", 32'(v), 32'(n > 0));
         if (k == n) begin
            chk("end_valid", 32'(tvalid), 32'd0);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_done", 32'(done), 32'd1);
            chk("end_last", 32'(tlast), 32'd0);
            fin = 1'b1;
         end else begin
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (prev_v && !prev_hs) chk("valid_held", 32'(v), 32'd1);
            if (after_hs) begin
               since++;
               if (since == dv + 1) chk("spacing", 32'(v), 32'd1);
               else chk("gap_valid", 32'(v), 32'd0);
               if (v) after_hs = 1'b0;
            end
            if (v) begin
               chk("tdata", 32'(tdata), 32'(model(m, a, k)));
               chk("tlast", 32'(tlast), 32'(k == n - 1));
            end
            tready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < pct);
            hs = v && tready;
            if (hs) begin
               if (k == 0) first_v = tdata;
               final_v = tdata;
               k++;
               beats++;
               after_hs = (k < n);
               since = 0;
            end
            prev_v = v;
            prev_hs = hs;
            // Starts while a burst is running must be ignored, as must later config changes.
            start = !hs && (cyc == 1 || $urandom_range(4) == 0);
         end
         mode = 2'($urandom_range(3));
         num_samples = 16'($urandom_range(20));
         amplitude = 16'($urandom);
         rate_div = 8'($urandom_range(5));
      end
      if (!fin) chk("timeout", 32'd0, 32'd1);
      start = 1'b0;
      @(negedge aclk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_valid", 32'(tvalid), 32'd0);
   endtask

   typedef struct {
      logic [1:0]  mode;
      int          n;
      logic [15:0] amp;
      int          div;
      int          pct;
      int          stall;
      logic [15:0] exp_first;
      logic [15:0] exp_final;
      int          exp_beats;
   } vec_t;

   vec_t        tbl[10];
   logic [15:0] f_v, l_v;
   int          nb;

   initial begin
      tbl[0] = '{2'd0, 4, 16'd1000, 0, 100, 0, 16'h03E8, 16'h0000, 4};
      tbl[1] = '{2'd2, 3, 16'h7000, 0, 100, 0, 16'h0000, 16'hE000, 3};
      tbl[2] = '{2'd3, 2, 16'h8000, 0, 100, 0, 16'h8000, 16'h8000, 2};
      tbl[3] = '{2'd1, 4, 16'd5,    0, 100, 3, 16'h0005, 16'h0005, 4};
      tbl[4] = '{2'd0, 3, 16'h0BEE, 2, 100, 0, 16'h0BEE, 16'h0000, 3};
      tbl[5] = '{2'd0, 0, 16'h1234, 0, 100, 0, 16'h0000, 16'h0000, 0};
      tbl[6] = '{2'd3, 4, 16'd3,    1, 60,  0, 16'h0003, 16'hFFFD, 4};
      tbl[7] = '{2'd2, 5, 16'hFFFF, 3, 70,  0, 16'h0000, 16'hFFFC, 5};
      tbl[8] = '{2'd0, 1, 16'h1234, 5, 50,  0, 16'h1234, 16'h1234, 1};
      tbl[9] = '{2'd1, 6, 16'h8001, 1, 40,  2, 16'h8001, 16'h8001, 6};

      #2 aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      chk("rst_valid", 32'(tvalid), 32'd0);
      chk("rst_data", 32'(tdata), 32'd0);
      chk("rst_last", 32'(tlast), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("post_rst_valid", 32'(tvalid), 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_burst(tbl[i].mode, tbl[i].n, tbl[i].amp, tbl[i].div, tbl[i].pct, tbl[i].stall,
                   f_v, l_v, nb);
         chk($sformatf("tbl%0d_beats", i), 32'(nb), 32'(tbl[i].exp_beats));
         chk($sformatf("tbl%0d_first", i), 32'(f_v), 32'(tbl[i].exp_first));
         chk($sformatf("tbl%0d_final", i), 32'(l_v), 32'(tbl[i].exp_final));
      end

      for (int i = 0; i < 25; i++) begin
         int rn;
         rn = int'($urandom_range(12));
         run_burst(2'($urandom_range(3)), rn, 16'($urandom), int'($urandom_range(3)),
                   int'($urandom_range(100, 30)), int'($urandom_range(2)), f_v, l_v, nb);
         chk($sformatf("rand%0d_beats", i), 32'(nb), 32'(rn));
      end

      // Reset during the second beat, then a fresh burst must restart from k=0.
      @(negedge aclk);
      start = 1'b1; mode = 2'd1; num_samples = 16'd10; amplitude = 16'd7; rate_div = 8'd0;
      tready = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      @(negedge aclk);
      chk("second_beat_valid", 32'(tvalid), 32'd1);
      chk("second_beat_data", 32'(tdata), 32'd7);
      aresetn = 1'b0;
      #1;
      chk("midrst_valid", 32'(tvalid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_data", 32'(tdata), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      tready = 1'b0;
      run_burst(2'd2, 4, 16'd3, 0, 100, 0, f_v, l_v, nb);
      chk("fresh_beats", 32'(nb), 32'd4);
      chk("fresh_first", 32'(f_v), 32'd0);
      chk("fresh_final", 32'(l_v), 32'd9);

      // Longest burst: index counter must reach the end without wrapping.
      run_burst(2'd1, 65535, 16'h1111, 0, 100, 0, f_v, l_v, nb);
      chk("max_beats", 32'(nb), 32'd65535);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axis_sample_source.md
Name: axis_sample_source

Overview:
- AXI4-Stream master that generates directed test waveforms and drives the s_axis_data_* slave port of the team's 16-bit FIR filters.
- It is the transmit end of the filter's input stream: it owns tvalid and tdata, and obeys tready backpressure.
- Used in filter benches and in on-chip self-test to feed impulse, step, ramp or alternating sequences of programmable length and rate.

Parameters:
- DATA_W, 16, sample width in bits; matches the filter's tdata.
- CNT_W, 16, width of the sample counter and num_samples.
- DIV_W, 8, width of the inter-sample gap counter.

Ports:
- aclk  in  1  system clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- mode  in  2  waveform select: 0 impulse, 1 step, 2 ramp, 3 alternating.
- num_samples  in  CNT_W  number of beats in the burst; 0 is legal.
- amplitude  in  DATA_W  signed amplitude, or ramp increment.
- rate_div  in  DIV_W  idle cycles inserted after each accepted beat.
- m_axis_data_tvalid  out  1  stream valid.
- m_axis_data_tdata  out  DATA_W  signed sample.
- m_axis_data_tready  in  1  sink ready.
- m_axis_data_tlast  out  1  marks the final beat of the burst.
- busy  out  1  high from burst start until the final beat is accepted.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - tvalid=0, tdata=0, tlast=0, busy=0, done=0.
  - All counters and captured configuration cleared.
  - Reset asserted mid-burst drops tvalid immediately; no partial state survives.
- All outputs are registered.
- Configuration capture: mode, num_samples, amplitude and rate_div are captured on the accepted start. Later input changes do not affect the running burst.
- FSM states: IDLE, SEND, GAP.
  - IDLE, start=1, num_samples>0: go to SEND next cycle. busy=1, tvalid=1, first sample on tdata (latency 1 cycle from start).
  - IDLE, start=1, num_samples=0: stay in IDLE, no beat, done=1 on the next cycle, busy stays 0.
  - SEND: tvalid=1.
    - tdata and tlast are held stable while tready=0 (AXI rule). tvalid never drops without a handshake.
    - Handshake = tvalid & tready at the clock edge.
  - SEND, handshake on a non-final beat:
    - rate_div=0: stay in SEND and present the next sample the following cycle (back-to-back, one beat per cycle).
    - rate_div>0: go to GAP with tvalid=0.
  - GAP: count rate_div cycles with tvalid=0, then return to SEND with the next sample. Consecutive beats are therefore spaced exactly rate_div+1 cycles when tready is held high.
  - SEND, handshake on the final beat (sample index k = num_samples-1): go to IDLE. tvalid=0, tlast=0, busy=0 and done=1, all on the cycle after the handshake.
  - start is ignored in SEND and GAP.
- tlast is 1 only while the final beat is presented.
- Sample value for index k (0-based), all arithmetic mod 2^DATA_W two's complement:
  - impulse: amplitude at k=0, else 0.
  - step: amplitude for every k.
  - ramp: k*amplitude, computed as a running accumulator starting at 0 and adding amplitude after each handshake. Wraps silently.
  - alternating: amplitude for even k, -amplitude for odd k. -(-32768) wraps to -32768.
- Sample index counter width is CNT_W. num_samples=65535 completes without counter wrap.

Decomposition:
- Shared package axis_src_pkg:
  - mode constants MODE_IMPULSE/STEP/RAMP/ALT.
  - state enum IDLE/SEND/GAP.
  - DATA_W default.
- One natural sub-module, axis_sample_value_gen, holds the ramp accumulator, the alternating-sign toggle and the impulse first-beat flag. It computes the next sample on advance, with clear on start.
- The top level holds the FSM, the counters and the AXI handshake.

Test Plan:
- Impulse, num_samples=4, amplitude=1000, rate_div=0, tready=1 -> start at cycle 0; tdata 1000,0,0,0 on cycles 1-4; tlast on cycle 4; done pulse on cycle 5.
- Ramp, num_samples=3, amplitude=0x7000, tready=1 -> tdata 0x0000, 0x7000, 0xE000 (wrap), tlast on the third beat.
- Alternating, amplitude=-32768, num_samples=2 -> tdata 0x8000, 0x8000; busy falls the cycle after the second handshake.
- Backpressure: step, amplitude=5, tready=0 for 3 cycles after start -> tvalid=1 and tdata=5 held stable for all stall cycles; exactly num_samples beats total.
- Rate: rate_div=2, num_samples=3, tready=1 -> beats on cycles 1, 4, 7; start pulsed on cycle 2 is ignored.
- Edge cases:
  - num_samples=0 -> no tvalid, done on the cycle after start.
  - aresetn low during the second beat -> tvalid=0 immediately.
  - After release, a new start produces a fresh burst from k=0.
